// File: rtl/window_buffer.sv
// Sliding KSIZE x KSIZE window generator for raster-order pixel streams.
// Line memories supply the upper rows of each new window column.
module window_buffer #(
    parameter int WIDTH    = 16,
    parameter int KSIZE    = 3,
    parameter int MAX_COLS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ce,
    input  logic                             sof,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 data_in,
    input  logic [$clog2(MAX_COLS+1)-1:0]    cols,
    input  logic [15:0]                      rows,
    output logic [KSIZE*KSIZE*WIDTH-1:0]     window,
    output logic                             win_valid,
    output logic                             frame_done,
    output logic                             cfg_err
);

    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int NL = KSIZE - 1;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      col_reg, col_next;
    logic [CW-1:0]      cols_reg, cols_next;
    logic [15:0]        row_reg, row_next;
    logic [15:0]        rows_reg, rows_next;
    logic               win_valid_reg, win_valid_next;
    logic               frame_done_reg, frame_done_next;
    logic               cfg_err_reg, cfg_err_next;

    logic               accept;
    logic               cfg_legal;
    logic               last_col;
    logic               last_row;
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic [NL*WIDTH-1:0]    lm_out;     // slice 0 = previous row, slice NL-1 = oldest row
    logic [KSIZE*WIDTH-1:0] col_in;     // slice 0 = top of the incoming column
    logic [WIDTH-1:0]   win_reg [KSIZE][KSIZE];

    assign accept    = ce & in_valid & ((state_reg == S_ACTIVE) | sof);
    assign cfg_legal = (cols >= CW'(KSIZE)) && (cols <= CW'(MAX_COLS)) && (rows >= 16'(KSIZE));
    assign last_col  = ((CW+1)'(col_reg) + (CW+1)'(1)) == (CW+1)'(cols_reg);
    assign last_row  = (17'(row_reg) + 17'd1) == 17'(rows_reg);

    // --- control: next-state logic ---
    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        cols_next       = cols_reg;
        rows_next       = rows_reg;
        win_valid_next  = win_valid_reg;
        frame_done_next = frame_done_reg;
        cfg_err_next    = cfg_err_reg;

        if (ce) begin
            win_valid_next  = 1'b0;
            frame_done_next = 1'b0;
        end

        if (accept) begin
            if (sof) begin
                // The sof beat is pixel (0,0); counters advance past it immediately.
                cols_next    = cols;
                rows_next    = rows;
                col_next     = CW'(1);
                row_next     = '0;
                cfg_err_next = ~cfg_legal;
                state_next   = cfg_legal ? S_ACTIVE : S_IDLE;
            end else begin
                win_valid_next = (row_reg >= 16'(KSIZE-1)) && (col_reg >= CW'(KSIZE-1));
                if (last_col) begin
                    col_next = '0;
                    if (last_row) begin
                        row_next        = '0;
                        state_next      = S_IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        row_next = row_reg + 16'd1;
                    end
                end else begin
                    col_next = col_reg + CW'(1);
                end
            end
        end
    end

    // --- control: state register ---
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            cols_reg       <= '0;
            rows_reg       <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            cols_reg       <= cols_next;
            rows_reg       <= rows_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
            cfg_err_reg    <= cfg_err_next;
        end
    end

    // Read data is prefetched for the column of the next pixel, so it is ready when it arrives.
    assign wr_addr = sof ? '0 : col_reg[AW-1:0];
    assign rd_addr = col_next[AW-1:0];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_line
            logic [WIDTH-1:0] mem [0:MAX_COLS-1];
            logic [WIDTH-1:0] rd_q;
            logic [WIDTH-1:0] wr_d;

            if (gi == 0) begin : g_first
                assign wr_d = data_in;
            end else begin : g_chain
                assign wr_d = lm_out[(gi-1)*WIDTH +: WIDTH];
            end

            always_ff @(posedge clk) begin
                if (ce) begin
                    if (accept) begin
                        mem[wr_addr] <= wr_d;
                    end
                    rd_q <= mem[rd_addr];
                end
            end

            assign lm_out[gi*WIDTH +: WIDTH] = rd_q;
        end

        for (gi = 0; gi < KSIZE; gi++) begin : g_col
            if (gi == KSIZE-1) begin : g_new
                assign col_in[gi*WIDTH +: WIDTH] = data_in;
            end else begin : g_mem
                assign col_in[gi*WIDTH +: WIDTH] = lm_out[(KSIZE-2-gi)*WIDTH +: WIDTH];
            end
        end

        for (gi = 0; gi < KSIZE; gi++) begin : g_win_row
            for (gj = 0; gj < KSIZE; gj++) begin : g_win_col
                assign window[((gi*KSIZE)+gj)*WIDTH +: WIDTH] = win_reg[gi][gj];
            end
        end
    endgenerate

    // --- window register array: shift left, new column enters on the right ---
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win_reg[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE-1; j++) begin
                    win_reg[i][j] <= win_reg[i][j+1];
                end
                win_reg[i][KSIZE-1] <= col_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;
    assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: directed frames plus random frames checked against
// an image-array reference model that builds each window from pixel coordinates.
module tb_window_buffer;

    localparam int WIDTH    = 16;
    localparam int KSIZE    = 3;
    localparam int MAX_COLS = 32;
    localparam int CW       = $clog2(MAX_COLS + 1);
    localparam int WW       = KSIZE * KSIZE * WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ce = 1'b0;
    logic              sof = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic [CW-1:0]     cols = '0;
    logic [15:0]       rows = '0;
    logic [WW-1:0]     window;
    logic              win_valid;
    logic              frame_done;
    logic              cfg_err;

    window_buffer #(
        .WIDTH    (WIDTH),
        .KSIZE    (KSIZE),
        .MAX_COLS (MAX_COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sof        (sof),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .cols       (cols),
        .rows       (rows),
        .window     (window),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // reference model state
    int            m_active, m_err, m_r, m_c, m_cols, m_rows;
    logic          m_wv, m_fd;
    logic [WW-1:0] m_win;
    bit            m_known;
    int            img [64][MAX_COLS];

    int            n_assert = 0;
    int            n_fail = 0;
    int            win_cnt, fd_cnt;
    bit            got_first;
    logic [WW-1:0] first_win, last_win;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] win_of(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                w[((i*KSIZE)+j)*WIDTH +: WIDTH] = WIDTH'(img[r-KSIZE+1+i][c-KSIZE+1+j]);
        return w;
    endfunction

    // window of a "value = r*cols+c" frame whose top-left pixel is (br,bc)
    function automatic logic [WW-1:0] pack(input int br, input int bc, input int cv);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                w[((i*KSIZE)+j)*WIDTH +: WIDTH] = WIDTH'((br+i)*cv + bc + j);
        return w;
    endfunction

    task automatic model_reset();
        m_active = 0; m_err = 0; m_r = 0; m_c = 0;
        m_wv = 1'b0; m_fd = 1'b0; m_win = '0; m_known = 1'b1;
    endtask

    task automatic model_clock(input bit ce_v, input bit sof_v, input bit iv_v,
                               input int d, input int cv, input int rv);
        bit acc;
        acc = ce_v && iv_v && ((m_active != 0) || sof_v);
        if (ce_v) begin
            m_wv = 1'b0;
            m_fd = 1'b0;
        end
        if (acc) begin
            if (sof_v) begin
                m_cols = cv; m_rows = rv; m_r = 0; m_c = 0;
                m_active = (cv >= KSIZE && cv <= MAX_COLS && rv >= KSIZE) ? 1 : 0;
                m_err = (m_active != 0) ? 0 : 1;
            end
            m_known = 1'b0;
            if (m_active != 0) begin
                img[m_r][m_c] = d;
                if (m_r >= KSIZE-1 && m_c >= KSIZE-1) begin
                    m_wv = 1'b1;
                    m_win = win_of(m_r, m_c);
                    m_known = 1'b1;
                end
                if (m_r == m_rows-1 && m_c == m_cols-1) begin
                    m_fd = 1'b1; m_active = 0; m_r = 0; m_c = 0;
                end else if (m_c == m_cols-1) begin
                    m_c = 0; m_r++;
                end else begin
                    m_c++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("win_valid", WW'(win_valid), WW'(m_wv));
        chk("frame_done", WW'(frame_done), WW'(m_fd));
        chk("cfg_err", WW'(cfg_err), WW'(m_err));
        if (m_known) chk("window", window, m_win);
    endtask

    task automatic step(input bit ce_v, input bit sof_v, input bit iv_v,
                        input int d, input int cv, input int rv);
        ce = ce_v; sof = sof_v; in_valid = iv_v;
        data_in = WIDTH'(d); cols = CW'(cv); rows = 16'(rv);
        @(posedge clk);
        model_clock(ce_v, sof_v, iv_v, d & 16'hFFFF, cv, rv);
        #1;
        check_outputs();
        if (ce_v && win_valid === 1'b1) begin
            win_cnt++;
            if (!got_first) begin
                first_win = window;
                got_first = 1'b1;
            end
            last_win = window;
        end
        if (ce_v && frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic clear_stats();
        win_cnt = 0; fd_cnt = 0; got_first = 1'b0;
        first_win = '0; last_win = '0;
    endtask

    task automatic frame(input int cv, input int rv, input int stall_after,
                         input bit rnd_data, input bit rnd_gaps, input int abort_at);
        int d;
        bit g_ce, g_iv;
        for (int p = 0; p < cv*rv; p++) begin
            if (abort_at >= 0 && p == abort_at) return;
            d = rnd_data ? int'($urandom_range(0, 65535)) : p;
            if (rnd_gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    g_ce = 1'($urandom_range(0, 1));
                    g_iv = g_ce ? 1'b0 : 1'($urandom_range(0, 1));
                    step(g_ce, 1'b0, g_iv, int'($urandom_range(0, 65535)), cv, rv);
                end
            end
            step(1'b1, p == 0, 1'b1, d, cv, rv);
            if (p == stall_after) begin
                repeat (3) step(1'b0, 1'b0, 1'b1, 16'hBEEF, cv, rv);
                repeat (2) step(1'b1, 1'b0, 1'b0, 16'hDEAD, cv, rv);
            end
        end
        step(1'b1, 1'b0, 1'b0, 0, cv, rv);
    endtask

    task automatic basic_stats(input string tag);
        chk({tag, "_win_count"}, WW'(win_cnt), WW'(6));
        chk({tag, "_done_count"}, WW'(fd_cnt), WW'(1));
        chk({tag, "_first_win"}, first_win, pack(0, 0, 5));
        chk({tag, "_last_win"}, last_win, pack(1, 2, 5));
    endtask

    initial begin
        int cv, rv, ab;
        model_reset();
        clear_stats();

        // reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_window", window, '0);
        #2 rst = 1'b1;

        // pixel without sof after reset is ignored
        step(1'b1, 1'b0, 1'b1, 77, 5, 4);
        step(1'b1, 1'b0, 1'b1, 78, 5, 4);

        // basic frame
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, -1);
        basic_stats("basic");

        // stall after value 13
        clear_stats();
        frame(5, 4, 13, 1'b0, 1'b0, -1);
        basic_stats("stall");

        // illegal configuration, then legal frame
        step(1'b1, 1'b1, 1'b1, 0, 2, 4);
        chk("cfg_err_set", WW'(cfg_err), WW'(1));
        clear_stats();
        repeat (8) step(1'b1, 1'b0, 1'b1, 5, 2, 4);
        chk("cfg_err_no_win", WW'(win_cnt), WW'(0));
        chk("cfg_err_no_done", WW'(fd_cnt), WW'(0));
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, -1);
        basic_stats("after_cfg_err");

        // mid-frame restart at pixel (2,3)
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, 13);
        chk("abort_no_done", WW'(fd_cnt), WW'(0));
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, -1);
        basic_stats("restart");

        // asynchronous reset after value 12
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, 13);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_rst_window", window, '0);
        @(posedge clk);
        #1;
        check_outputs();
        #2 rst = 1'b1;
        repeat (4) step(1'b1, 1'b0, 1'b1, 99, 5, 4);
        clear_stats();
        frame(5, 4, -1, 1'b0, 1'b0, -1);
        basic_stats("post_reset");

        // random frames, gaps, aborts and illegal configurations
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                cv = int'($urandom_range(0, 63));
                rv = (cv >= KSIZE && cv <= MAX_COLS) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 9));
                step(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 65535)), cv, rv);
                repeat (5) step(1'b1, 1'b0, 1'b1, int'($urandom_range(0, 65535)), cv, rv);
            end
            cv = int'($urandom_range(KSIZE, MAX_COLS));
            rv = int'($urandom_range(KSIZE, 10));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cv*rv-1)) : -1;
            frame(cv, rv, -1, 1'b1, 1'b1, ab);
        end
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
